fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Four-way write arbiter in front of a single FIFO write port.
//             Round-robin grant between requesters, with optional locked
//             bursts of up to MAX_BURST consecutive words for the owner.
//             The word moves to the FIFO in the same cycle it is granted.
//  Ports    : clk      - write clock, all state changes on its rising edge
//             reset    - synchronous, active-high reset
//             req      - per-requester valid word
//             lock     - per-requester request to keep the grant
//             data_req - requester words, requester i at [i*WIDTH +: WIDTH]
//             full     - FIFO full flag
//             put      - FIFO write strobe
//             data_in  - word driven to the FIFO
//             ack      - one-hot, requester whose word is written this cycle
//             busy     - high while a locked burst is in progress
//             owner    - index of the current or last granted requester
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [3:0]         lock,
    input  logic [4*WIDTH-1:0] data_req,
    input  logic               full,
    output logic               put,
    output logic [WIDTH-1:0]   data_in,
    output logic [3:0]         ack,
    output logic               busy,
    output logic [1:0]         owner
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_BURST  = 1'b1;
    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);
    // A burst of one word is just an ordinary grant, so BURST is never entered.
    localparam bit         c_BURST_EN  = (MAX_BURST > 1);

    logic [0:0]       r_state;
    logic [1:0]       r_rr_ptr;
    logic [1:0]       r_owner;
    logic [3:0]       r_burst_cnt;
    logic [WIDTH-1:0] r_data_hold;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_rr_ptr_nxt;
    logic [1:0]       w_owner_nxt;
    logic [3:0]       w_burst_cnt_nxt;
    logic [WIDTH-1:0] w_data_hold_nxt;

    logic [WIDTH-1:0] w_words [4];
    logic [3:0]       w_req_rot;
    logic             w_found;
    logic [1:0]       w_offset;
    logic [1:0]       w_sel;
    logic             w_xfer;
    logic [3:0]       w_cnt_inc;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign w_words[gi] = data_req[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate requests so bit 0 is the requester at rr_ptr; the first set bit
    // of the rotated vector is then the round-robin winner's offset.
    always_comb begin
        w_req_rot = req;
        case (r_rr_ptr)
            2'd0:    w_req_rot = req;
            2'd1:    w_req_rot = {req[0],   req[3:1]};
            2'd2:    w_req_rot = {req[1:0], req[3:2]};
            default: w_req_rot = {req[2:0], req[3]};
        endcase
    end

    always_comb begin
        w_found  = 1'b1;
        w_offset = 2'd0;
        if (w_req_rot[0])      w_offset = 2'd0;
        else if (w_req_rot[1]) w_offset = 2'd1;
        else if (w_req_rot[2]) w_offset = 2'd2;
        else if (w_req_rot[3]) w_offset = 2'd3;
        else                   w_found  = 1'b0;
    end

    // In BURST only the owner is eligible; otherwise the round-robin winner.
    assign w_sel     = (r_state == c_ST_BURST) ? r_owner : (r_rr_ptr + w_offset);
    assign w_xfer    = !reset && !full &&
                       ((r_state == c_ST_BURST) ? req[r_owner] : w_found);
    assign w_cnt_inc = r_burst_cnt + 4'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_rr_ptr    <= 2'd0;
            r_owner     <= 2'd0;
            r_burst_cnt <= 4'd0;
            r_data_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_data_hold <= w_data_hold_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_data_hold_nxt = w_xfer ? w_words[w_sel] : r_data_hold;
        case (r_state)
            c_ST_IDLE: begin
                if (w_xfer) begin
                    w_rr_ptr_nxt = w_sel + 2'd1;
                    w_owner_nxt  = w_sel;
                    if (c_BURST_EN && lock[w_sel]) begin
                        w_state_nxt     = c_ST_BURST;
                        w_burst_cnt_nxt = 4'd1;
                    end
                end
            end
            c_ST_BURST: begin
                // full freezes the burst entirely; state and count hold.
                if (!full) begin
                    if (!req[r_owner]) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_burst_cnt_nxt = w_cnt_inc;
                        if (!lock[r_owner] || (w_cnt_inc == c_MAX_BURST)) begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs; data_in falls back to the last written word when idle.
    always_comb begin
        put     = w_xfer;
        ack     = 4'b0000;
        data_in = r_data_hold;
        if (w_xfer) begin
            ack[w_sel] = 1'b1;
            data_in    = w_words[w_sel];
        end
    end

    assign busy  = (r_state == c_ST_BURST);
    assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter, directed scenarios
//             plus randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int c_W    = 8;
    localparam int c_MAXB = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     req;
    logic [3:0]     lock;
    logic [4*c_W-1:0] data_req;
    logic           full;
    logic           put;
    logic [c_W-1:0] data_in;
    logic [3:0]     ack;
    logic           busy;
    logic [1:0]     owner;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (spec-level view).
    bit             m_burst;
    int             m_ptr;
    int             m_owner;
    int             m_cnt;
    logic [c_W-1:0] m_last;

    // Inputs of the current cycle and the prediction for it.
    logic [3:0]     s_req, s_lock;
    logic           s_full, s_rst;
    int             s_grant;
    logic [c_W-1:0] s_word;
    logic [15:0]    exp_vec;

    fifo_wr_arbiter #(.WIDTH(c_W), .MAX_BURST(c_MAXB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .data_req (data_req),
        .full     (full),
        .put      (put),
        .data_in  (data_in),
        .ack      (ack),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and predict the outputs.
    task automatic predict(input logic [3:0] rq, input logic [3:0] lk,
                           input logic fl, input logic rs, input logic [31:0] d);
        logic [3:0] eack;
        @(negedge clk);
        req = rq; lock = lk; full = fl; reset = rs; data_req = d;
        s_req = rq; s_lock = lk; s_full = fl; s_rst = rs;
        s_grant = -1;
        if (!rs && !fl) begin
            if (m_burst) begin
                if (rq[m_owner]) s_grant = m_owner;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (rq[(m_ptr + k) % 4]) begin
                        s_grant = (m_ptr + k) % 4;
                        break;
                    end
                end
            end
        end
        eack   = 4'b0000;
        s_word = m_last;
        if (s_grant >= 0) begin
            eack[s_grant] = 1'b1;
            s_word        = d[s_grant*c_W +: c_W];
        end
        exp_vec = {(s_grant >= 0), eack, s_word, m_burst, 2'(m_owner)};
        #1;
    endtask

    // Clock edge, then advance the model by the spec rules.
    task automatic advance();
        @(posedge clk);
        if (s_rst) begin
            m_burst = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_last = '0;
        end else if (m_burst) begin
            if (!s_full) begin
                if (!s_req[m_owner]) begin
                    m_burst = 0;
                end else begin
                    m_cnt++;
                    m_last = s_word;
                    if (!s_lock[m_owner] || m_cnt == c_MAXB) m_burst = 0;
                end
            end
        end else if (s_grant >= 0) begin
            m_ptr   = (s_grant + 1) % 4;
            m_owner = s_grant;
            m_last  = s_word;
            if (s_lock[s_grant] && c_MAXB > 1) begin
                m_burst = 1;
                m_cnt   = 1;
            end
        end
    endtask

    task automatic do_reset();
        predict(4'h0, 4'h0, 1'b0, 1'b1, $urandom);
        advance();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            predict(4'($urandom), 4'($urandom), 1'($urandom), 1'b1, $urandom);
            checks++;
            if ({put, ack, data_in, busy, owner} !== exp_vec) begin
                errors++;
                $display("FAIL reset cyc%0d got %h exp %h", i, {put, ack, data_in, busy, owner}, exp_vec);
            end
            checks++;
            if (put !== 1'b0 || ack !== 4'b0000 || data_in !== '0) begin
                errors++;
                $display("FAIL reset_force cyc%0d got put=%b ack=%b data=%h exp 0/0000/00", i, put, ack, data_in);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            predict(4'hF, 4'h0, 1'b0, 1'b0, $urandom);
            checks++;
            if ({put, ack, data_in, busy, owner} !== exp_vec) begin
                errors++;
                $display("FAIL round_robin cyc%0d got %h exp %h", i, {put, ack, data_in, busy, owner}, exp_vec);
            end
            checks++;
            if (ack !== (4'b0001 << i) || data_in !== data_req[i*c_W +: c_W]) begin
                errors++;
                $display("FAIL rr_seq cyc%0d got ack=%b data=%h exp ack=%b", i, ack, data_in, 4'b0001 << i);
            end
            advance();
        end
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            predict(4'b0101, 4'b0001, 1'b0, 1'b0, $urandom);
            checks++;
            if ({put, ack, data_in, busy, owner} !== exp_vec) begin
                errors++;
                $display("FAIL burst cyc%0d got %h exp %h", i, {put, ack, data_in, busy, owner}, exp_vec);
            end
            checks++;
            if (ack !== ((i < 4) ? 4'b0001 : 4'b0100) || busy !== (i >= 1 && i <= 3)) begin
                errors++;
                $display("FAIL burst_seq cyc%0d got ack=%b busy=%b", i, ack, busy);
            end
            advance();
        end
    endtask

    task automatic test_burst_full();
        logic [7:0] fl_pat = 8'b0001_1100;   // bit i = full in cycle i
        do_reset();
        for (int i = 0; i < 8; i++) begin
            predict(4'b0001, 4'b0001, fl_pat[i], 1'b0, $urandom);
            checks++;
            if ({put, ack, data_in, busy, owner} !== exp_vec) begin
                errors++;
                $display("FAIL burst_full cyc%0d got %h exp %h", i, {put, ack, data_in, busy, owner}, exp_vec);
            end
            checks++;
            if (fl_pat[i] && put !== 1'b0) begin
                errors++;
                $display("FAIL burst_full_put cyc%0d got put=%b exp 0", i, put);
            end
            advance();
        end
    endtask

    task automatic test_burst_drop();
        logic [3:0] rq [3] = '{4'b0011, 4'b0010, 4'b0010};
        logic [3:0] ea [3] = '{4'b0001, 4'b0000, 4'b0010};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            predict(rq[i], 4'b0001, 1'b0, 1'b0, $urandom);
            checks++;
            if ({put, ack, data_in, busy, owner} !== exp_vec) begin
                errors++;
                $display("FAIL burst_drop cyc%0d got %h exp %h", i, {put, ack, data_in, busy, owner}, exp_vec);
            end
            checks++;
            if (ack !== ea[i]) begin
                errors++;
                $display("FAIL burst_drop_ack cyc%0d got %b exp %b", i, ack, ea[i]);
            end
            advance();
        end
    endtask

    task automatic test_full_hold();
        int ptr_before;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            predict(4'($urandom), 4'h0, 1'b0, 1'b0, $urandom);
            advance();
        end
        ptr_before = m_ptr;
        for (int i = 0; i < 6; i++) begin
            predict(4'hF, 4'h0, (i < 5), 1'b0, $urandom);
            checks++;
            if ({put, ack, data_in, busy, owner} !== exp_vec) begin
                errors++;
                $display("FAIL full_hold cyc%0d got %h exp %h", i, {put, ack, data_in, busy, owner}, exp_vec);
            end
            checks++;
            if ((i < 5 && put !== 1'b0) || (i == 5 && ack !== (4'b0001 << ptr_before))) begin
                errors++;
                $display("FAIL full_hold_grant cyc%0d got put=%b ack=%b exp ptr %0d", i, put, ack, ptr_before);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        predict(4'hF, 4'b0001, 1'b0, 1'b0, $urandom);
        advance();
        predict(4'hF, 4'hF, 1'b0, 1'b1, $urandom);
        checks++;
        if (put !== 1'b0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_force got put=%b ack=%b exp 0/0000", put, ack);
        end
        advance();
        predict(4'b1000, 4'h0, 1'b0, 1'b0, $urandom);
        checks++;
        if ({put, ack, data_in, busy, owner} !== exp_vec) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", {put, ack, data_in, busy, owner}, exp_vec);
        end
        checks++;
        if (ack !== 4'b1000 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_grant got ack=%b busy=%b owner=%0d exp 1000/0/0", ack, busy, owner);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            predict(4'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0), $urandom);
            checks++;
            if ({put, ack, data_in, busy, owner} !== exp_vec) begin
                errors++;
                $display("FAIL random cyc%0d got %h exp %h", i, {put, ack, data_in, busy, owner}, exp_vec);
            end
            advance();
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; lock = '0; full = 1'b0; data_req = '0;
        s_req = '0; s_lock = '0; s_full = 1'b0; s_rst = 1'b1; s_grant = -1;
        s_word = '0; exp_vec = '0;
        m_burst = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_last = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_round_robin();
        test_burst();
        test_burst_full();
        test_burst_drop();
        test_full_hold();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
